// File: rtl/c3_pkg.sv
// Shared constants for the C3 window feeder: geometry, address widths, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package c3_pkg;

  // Geometry of the S2 feature map and the C3 kernels
  localparam int IFM_W    = 14;
  localparam int IFM_H    = 14;
  localparam int IN_CH    = 6;
  localparam int OUT_CH   = 16;
  localparam int K        = 5;
  localparam int DATA_W   = 8;

  // A window is K rows by K+1 columns, so one window feeds two adjacent outputs
  localparam int WIN_COLS = K + 1;
  localparam int WIN_PIX  = K * WIN_COLS;
  localparam int KER_PIX  = K * K;
  localparam int OUT_H    = IFM_H - K + 1;
  localparam int PAIRS    = (IFM_W - K + 1) / 2;

  // Address and counter widths
  localparam int IFM_AW   = 11;
  localparam int W_AW     = 12;
  localparam int K_W      = 5;
  localparam int OC_W     = 4;
  localparam int IC_W     = 3;
  localparam int ROW_W    = 4;
  localparam int P_W      = 3;
  localparam int SUB_W    = 3;

  // Read counts per load state; each load takes N+1 cycles
  localparam logic [K_W-1:0] N_LOAD_W     = 5'd25;
  localparam logic [K_W-1:0] N_LOAD_FULL  = 5'd30;
  localparam logic [K_W-1:0] N_LOAD_SHIFT = 5'd10;

  // FSM encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LOAD_W     = 3'd1;
  localparam logic [2:0] ST_LOAD_FULL  = 3'd2;
  localparam logic [2:0] ST_EMIT       = 3'd3;
  localparam logic [2:0] ST_LOAD_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

endpackage

// File: rtl/c3_feeder_addr_gen.sv
// Loop counters (oc, ic, row, pair, k) and the S2/weight read address arithmetic.
// Latency: addresses and strobes are combinational from the counter registers.
// Backpressure: none; counters advance purely on the FSM state supplied by the top.
// Ports: state_i/start_go_i from the FSM; k/last flags/loop indices back to the FSM;
//        ifm_/w_ strobes and addresses straight to the memories (address 0 when idle).
module c3_feeder_addr_gen
  import c3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        state_i,
  input  logic              start_go_i,
  output logic [K_W-1:0]    k_o,
  output logic              k_last_o,
  output logic              p_last_o,
  output logic              row_last_o,
  output logic              ic_last_o,
  output logic              oc_last_o,
  output logic [OC_W-1:0]   oc_o,
  output logic [IC_W-1:0]   ic_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [P_W-1:0]    p_o,
  output logic              ifm_rd_en_o,
  output logic [IFM_AW-1:0] ifm_addr_o,
  output logic              w_rd_en_o,
  output logic [W_AW-1:0]   w_addr_o
);

  logic [K_W-1:0]   k_q, k_d;
  logic [SUB_W-1:0] sr_q, sr_d;   // window row of the next read
  logic [SUB_W-1:0] sc_q, sc_d;   // window column (or column offset in shift loads)
  logic [P_W-1:0]   p_q, p_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [IC_W-1:0]  ic_q, ic_d;
  logic [OC_W-1:0]  oc_q, oc_d;

  logic [K_W-1:0]   k_n;
  logic [SUB_W-1:0] sc_max;
  logic             is_load;
  logic             rd_phase;
  logic [3:0]       ifm_col;
  logic [IFM_AW-1:0] ifm_calc;
  logic [W_AW-1:0]  w_calc;

  always_comb begin
    k_n    = '0;
    sc_max = 3'd1;
    case (state_i)
      ST_LOAD_W:     k_n = N_LOAD_W;
      ST_LOAD_FULL:  begin k_n = N_LOAD_FULL;  sc_max = 3'(WIN_COLS - 1); end
      ST_LOAD_SHIFT: begin k_n = N_LOAD_SHIFT; sc_max = 3'd1; end
      default:       k_n = '0;
    endcase
  end

  assign is_load    = (state_i == ST_LOAD_W) || (state_i == ST_LOAD_FULL) ||
                      (state_i == ST_LOAD_SHIFT);
  assign k_last_o   = is_load && (k_q == k_n);
  assign rd_phase   = is_load && (k_q < k_n);

  assign p_last_o   = (p_q   == 3'(PAIRS - 1));
  assign row_last_o = (row_q == 4'(OUT_H - 1));
  assign ic_last_o  = (ic_q  == 3'(IN_CH - 1));
  assign oc_last_o  = (oc_q  == 4'(OUT_CH - 1));

  always_comb begin
    k_d   = k_q;
    sr_d  = sr_q;
    sc_d  = sc_q;
    p_d   = p_q;
    row_d = row_q;
    ic_d  = ic_q;
    oc_d  = oc_q;
    if (start_go_i) begin
      k_d   = '0;
      sr_d  = '0;
      sc_d  = '0;
      p_d   = '0;
      row_d = '0;
      ic_d  = '0;
      oc_d  = '0;
    end else begin
      case (state_i)
        ST_LOAD_W, ST_LOAD_FULL, ST_LOAD_SHIFT: begin
          if (k_last_o) begin
            k_d  = '0;
            sr_d = '0;
            sc_d = '0;
          end else begin
            k_d = k_q + 5'd1;
            // Kernel reads are linear in k; window reads walk row-major
            if (state_i != ST_LOAD_W) begin
              if (sc_q == sc_max) begin
                sc_d = '0;
                sr_d = sr_q + 3'd1;
              end else begin
                sc_d = sc_q + 3'd1;
              end
            end
          end
        end
        ST_EMIT: begin
          k_d  = '0;
          sr_d = '0;
          sc_d = '0;
          // Innermost loop first; the final window leaves the tags untouched
          if (!p_last_o) begin
            p_d = p_q + 3'd1;
          end else if (!row_last_o) begin
            p_d   = '0;
            row_d = row_q + 4'd1;
          end else if (!ic_last_o) begin
            p_d   = '0;
            row_d = '0;
            ic_d  = ic_q + 3'd1;
          end else if (!oc_last_o) begin
            p_d   = '0;
            row_d = '0;
            ic_d  = '0;
            oc_d  = oc_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      sr_q  <= '0;
      sc_q  <= '0;
      p_q   <= '0;
      row_q <= '0;
      ic_q  <= '0;
      oc_q  <= '0;
    end else begin
      k_q   <= k_d;
      sr_q  <= sr_d;
      sc_q  <= sc_d;
      p_q   <= p_d;
      row_q <= row_d;
      ic_q  <= ic_d;
      oc_q  <= oc_d;
    end
  end

  // p has already advanced when a shift load runs, so the new columns are 2p+4, 2p+5
  assign ifm_col  = (state_i == ST_LOAD_FULL) ? 4'(sc_q)
                                              : 4'({p_q, 1'b0}) + 4'(K - 1) + 4'(sc_q);
  assign ifm_calc = 11'(ic_q) * 11'(IFM_H * IFM_W)
                  + (11'(row_q) + 11'(sr_q)) * 11'(IFM_W)
                  + 11'(ifm_col);
  assign w_calc   = (12'(oc_q) * 12'(IN_CH) + 12'(ic_q)) * 12'(KER_PIX) + 12'(k_q);

  assign ifm_rd_en_o = rd_phase && (state_i != ST_LOAD_W);
  assign w_rd_en_o   = rd_phase && (state_i == ST_LOAD_W);
  assign ifm_addr_o  = ifm_rd_en_o ? ifm_calc : '0;
  assign w_addr_o    = w_rd_en_o   ? w_calc   : '0;

  assign k_o   = k_q;
  assign oc_o  = oc_q;
  assign ic_o  = ic_q;
  assign row_o = row_q;
  assign p_o   = p_q;

endmodule

// File: rtl/c3_window_feeder.sv
// Walks S2 (14x14x6) and C3 kernels (16x6x5x5), issuing one 5x6 window + 5x5 kernel per s2_valid.
// Latency: first s2_valid 58 cycles after start; then one window per 12 cycles within a row (80/row).
// Backpressure: none; the consumer must take every window on its s2_valid strobe.
// Ports: start/busy/done control; ifm_/w_ read strobe, address and 1-cycle-latency data;
//        s2_valid with packed s2_ifm/s2_weight and oc/ic/row/col tags for the accumulator.
module c3_window_feeder
  import c3_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      ifm_rd_en,
  output logic [IFM_AW-1:0]         ifm_rd_addr,
  input  logic [DATA_W-1:0]         ifm_rd_data,
  output logic                      w_rd_en,
  output logic [W_AW-1:0]           w_rd_addr,
  input  logic [DATA_W-1:0]         w_rd_data,
  output logic                      s2_valid,
  output logic [WIN_PIX*DATA_W-1:0] s2_ifm,
  output logic [KER_PIX*DATA_W-1:0] s2_weight,
  output logic [OC_W-1:0]           oc_idx,
  output logic [IC_W-1:0]           ic_idx,
  output logic [ROW_W-1:0]          out_row,
  output logic [3:0]                out_col
);

  logic [2:0]       state_q, state_d;
  logic [DATA_W-1:0] win_q [WIN_PIX];
  logic [DATA_W-1:0] ker_q [KER_PIX];

  logic             start_go;
  logic [K_W-1:0]   k;
  logic [K_W-1:0]   kcap;
  logic [K_W-1:0]   shift_slot;
  logic             k_last, p_last, row_last, ic_last, oc_last;
  logic [P_W-1:0]   p;

  assign start_go = (state_q == ST_IDLE) && start;

  c3_feeder_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .state_i     (state_q),
    .start_go_i  (start_go),
    .k_o         (k),
    .k_last_o    (k_last),
    .p_last_o    (p_last),
    .row_last_o  (row_last),
    .ic_last_o   (ic_last),
    .oc_last_o   (oc_last),
    .oc_o        (oc_idx),
    .ic_o        (ic_idx),
    .row_o       (out_row),
    .p_o         (p),
    .ifm_rd_en_o (ifm_rd_en),
    .ifm_addr_o  (ifm_rd_addr),
    .w_rd_en_o   (w_rd_en),
    .w_addr_o    (w_rd_addr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start) state_d = ST_LOAD_W;
      ST_LOAD_W:     if (k_last) state_d = ST_LOAD_FULL;
      ST_LOAD_FULL:  if (k_last) state_d = ST_EMIT;
      ST_LOAD_SHIFT: if (k_last) state_d = ST_EMIT;
      ST_EMIT: begin
        if (!p_last)        state_d = ST_LOAD_SHIFT;
        else if (!row_last) state_d = ST_LOAD_FULL;
        else if (!ic_last)  state_d = ST_LOAD_W;
        else if (!oc_last)  state_d = ST_LOAD_W;
        else                state_d = ST_DONE;
      end
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Data returning in cycle k belongs to the read issued at k-1
  assign kcap       = k - 5'd1;
  // Shift-load read j lands in window row j/2, column 4 + (j & 1)
  assign shift_slot = 5'(kcap[4:1]) * 5'(WIN_COLS) + 5'(K - 1) + 5'(kcap[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < WIN_PIX; i++) win_q[i] <= '0;
      for (int i = 0; i < KER_PIX; i++) ker_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD_W: begin
          if (k != '0) ker_q[kcap] <= w_rd_data;
        end
        ST_LOAD_FULL: begin
          if (k != '0) win_q[kcap] <= ifm_rd_data;
        end
        ST_LOAD_SHIFT: begin
          // Entry cycle slides the window two columns left; no capture is due yet
          if (k == '0) begin
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < WIN_COLS - 2; c++) begin
                win_q[r*WIN_COLS + c] <= win_q[r*WIN_COLS + c + 2];
              end
            end
          end else begin
            win_q[shift_slot] <= ifm_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s2_ifm = '0;
    for (int i = 0; i < WIN_PIX; i++) begin
      s2_ifm[(WIN_PIX-1-i)*DATA_W +: DATA_W] = win_q[i];
    end
  end

  always_comb begin
    s2_weight = '0;
    for (int i = 0; i < KER_PIX; i++) begin
      s2_weight[(KER_PIX-1-i)*DATA_W +: DATA_W] = ker_q[i];
    end
  end

  assign out_col  = {p, 1'b0};
  assign s2_valid = (state_q == ST_EMIT);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
